// File: rtl/fifo_ctrl_16x4_par.sv
// FIFO controller for a 2**ADDR_W x DATA_W dual-port RAM with a one-bit parity lane.
// Owns the pointers, occupancy and flags, generates EDI on write and checks EDO on read.
module fifo_ctrl_16x4_par #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Push,
  input  logic [DATA_W-1:0] PushData,
  input  logic              Pop,
  output logic [DATA_W-1:0] PopData,
  output logic              PopValid,
  output logic              PopErr,
  output logic              ErrSticky,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic              Underflow,
  output logic [DATA_W-1:0] RamData,
  output logic              RamEDI,
  output logic [ADDR_W-1:0] RamWrAddress,
  output logic              RamWrEn,
  output logic [ADDR_W-1:0] RamRdAddress,
  output logic              RamRdEn,
  input  logic [DATA_W-1:0] RamQ,
  input  logic              RamEDO
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic              PAR_SUM = (PARITY_ODD != 0);

  typedef struct packed {
    logic              par;
    logic [DATA_W-1:0] data;
  } ram_word_t;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;
  logic              pop_vld_q;
  logic              err_sticky_q, ovf_q, unf_q;
  ram_word_t         wr_word, rd_word;
  logic              rd_par_bad;

  // Flags come from registered state only, so Full blocks a simultaneous
  // push+pop write and Empty never lets a same-cycle push fall through.
  assign push_ok = Push & ~full_q;
  assign pop_ok  = Pop & ~empty_q;

  // Parity bit makes the XOR over the stored word equal PAR_SUM.
  assign wr_word.data = PushData;
  assign wr_word.par  = (^PushData) ^ PAR_SUM;

  assign rd_word.data = RamQ;
  assign rd_word.par  = RamEDO;
  assign rd_par_bad   = (^rd_word) != PAR_SUM;

  always_comb begin
    count_nxt = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      pop_vld_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q      <= count_nxt;
      full_q       <= (count_nxt == DEPTH);
      empty_q      <= (count_nxt == '0);
      // RAM registers the word on this edge; it is on Q next cycle.
      pop_vld_q    <= pop_ok;
      err_sticky_q <= err_sticky_q | (pop_vld_q & rd_par_bad);
      ovf_q        <= Push & full_q;
      unf_q        <= Pop & empty_q;
    end
  end

  assign RamWrEn      = push_ok;
  assign RamData      = wr_word.data;
  assign RamEDI       = wr_word.par;
  assign RamWrAddress = wr_ptr;
  assign RamRdEn      = pop_ok;
  assign RamRdAddress = rd_ptr;

  assign PopValid  = pop_vld_q;
  assign PopData   = pop_vld_q ? rd_word.data : '0;
  assign PopErr    = pop_vld_q & rd_par_bad;
  assign ErrSticky = err_sticky_q;
  assign Full      = full_q;
  assign Empty     = empty_q;
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule
